// File: rtl/fxp_div_pkg.sv
// fxp_div_pkg -- shared types and constants for the fixed-point divider.
//   state_e   : controller states (IDLE/LOAD/ITER/DONE)
//   DEF_WIDTH : default operand width
//   DEF_FRAC  : default fractional bits
//   cnt_width : iteration counter width, clog2(WIDTH+FRAC)
package fxp_div_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_LOAD = 2'b01,
    S_ITER = 2'b10,
    S_DONE = 2'b11
  } state_e;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_FRAC  = 8;

  function automatic int cnt_width(input int width, input int frac);
    return ((width + frac) <= 2) ? 1 : $clog2(width + frac);
  endfunction

endpackage

// File: rtl/fxp_div_if.sv
// fxp_div_if -- request/result bundle of the fixed-point divider.
//   master : drives start, a, b; observes q, valid, busy, dvz, ovf
//   slave  : the divider side
interface fxp_div_if #(parameter int WIDTH = fxp_div_pkg::DEF_WIDTH);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] q;
  logic             valid;
  logic             busy;
  logic             dvz;
  logic             ovf;

  modport master (output start, a, b, input q, valid, busy, dvz, ovf);
  modport slave  (input start, a, b, output q, valid, busy, dvz, ovf);
endinterface

// File: rtl/fxp_div_ctrl.sv
// fxp_div_ctrl -- sequencing FSM of the divider.
//   clk, sclr : clock, synchronous active-high reset
//   start_i   : division request (acted on only in IDLE)
//   bzero_i   : captured divisor is zero
//   abort_i   : overflow seen in the current iteration, finish early
//   load_o    : LOAD state strobe
//   shift_o   : ITER state strobe (one quotient bit per cycle)
//   done_o    : DONE state strobe
//   busy_o    : LOAD or ITER
//   cnt_o     : iteration counter, equals the index of the bit being produced
module fxp_div_ctrl
  import fxp_div_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int FRAC  = DEF_FRAC,
  parameter int CW    = cnt_width(WIDTH, FRAC)
) (
  input  logic          clk,
  input  logic          sclr,
  input  logic          start_i,
  input  logic          bzero_i,
  input  logic          abort_i,
  output logic          load_o,
  output logic          shift_o,
  output logic          done_o,
  output logic          busy_o,
  output logic [CW-1:0] cnt_o
);
  localparam int N = WIDTH + FRAC;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (sclr) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: if (start_i) state_d = S_LOAD;
      S_LOAD: begin
        if (bzero_i) state_d = S_DONE;
        else begin
          state_d = S_ITER;
          cnt_d   = CW'(N - 1);
        end
      end
      S_ITER: begin
        if (cnt_q == '0 || abort_i) state_d = S_DONE;
        else                        cnt_d   = cnt_q - CW'(1);
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign load_o  = (state_q == S_LOAD);
  assign shift_o = (state_q == S_ITER);
  assign done_o  = (state_q == S_DONE);
  assign busy_o  = load_o | shift_o;
  assign cnt_o   = cnt_q;
endmodule

// File: rtl/fxp_div_param.sv
// fxp_div_param -- iterative restoring divider, Q = (a << FRAC) / b,
// truncated toward zero, one quotient bit per cycle, MSB first.
//   clk, sclr : clock, synchronous active-high reset
//   bus       : fxp_div_if.slave (start, a, b in; q, valid, busy, dvz, ovf out)
// Build option: define FXP_DIV_SIGNED_EN for two's-complement operands
// (magnitudes are divided, sign applied on completion, signed saturation).
module fxp_div_param
  import fxp_div_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int FRAC  = DEF_FRAC
) (
  input  logic   clk,
  input  logic   sclr,
  fxp_div_if.slave bus
);
  localparam int N  = WIDTH + FRAC;
  localparam int CW = cnt_width(WIDTH, FRAC);

  logic          load, shift, done, busy, accept;
  logic [CW-1:0] cnt;

  logic [WIDTH-1:0] a_q, b_q, q_q;
  logic [WIDTH:0]   rem_q;
  logic [N-1:0]     dvd_q;
  logic [WIDTH-2:0] quo_q;
  logic             dvz_q, ovf_q;

  logic [WIDTH-1:0] a_in, b_in;
  logic [WIDTH+1:0] shifted, trial;
  logic             qbit, ovf_hit, fin, big, fin_ovf;
  logic [WIDTH-1:0] mag, res, sat, fin_q;

`ifdef FXP_DIV_SIGNED_EN
  logic sign_q;
  assign a_in = bus.a[WIDTH-1] ? -bus.a : bus.a;
  assign b_in = bus.b[WIDTH-1] ? -bus.b : bus.b;
`else
  assign a_in = bus.a;
  assign b_in = bus.b;
`endif

  // Controller only listens to start while idle, so accept mirrors that.
  assign accept = bus.start & ~busy & ~done;

  fxp_div_ctrl #(.WIDTH(WIDTH), .FRAC(FRAC), .CW(CW)) u_ctrl (
    .clk     (clk),
    .sclr    (sclr),
    .start_i (bus.start),
    .bzero_i (b_q == '0),
    .abort_i (ovf_hit),
    .load_o  (load),
    .shift_o (shift),
    .done_o  (done),
    .busy_o  (busy),
    .cnt_o   (cnt)
  );

  // Trial subtraction one bit wider than the remainder: the top bit of
  // trial is the borrow, so a clear borrow means the quotient bit is 1.
  assign shifted = {rem_q, dvd_q[N-1]};
  assign trial   = shifted - {2'b00, b_q};
  assign qbit    = ~trial[WIDTH+1];

  // The counter holds the index of the bit being produced; indices at or
  // above WIDTH cannot be represented in the result.
  assign ovf_hit = shift & qbit & (int'(cnt) >= WIDTH);
  assign fin     = shift & ((cnt == '0) | ovf_hit);
  assign mag     = {quo_q, qbit};

  always_comb begin
    big = 1'b0;
    res = mag;
    sat = '1;
`ifdef FXP_DIV_SIGNED_EN
    sat = sign_q ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    // Magnitude fits in WIDTH bits but may still exceed the signed range.
    big = mag[WIDTH-1] & (~sign_q | (mag[WIDTH-2:0] != '0));
    res = sign_q ? -mag : mag;
`endif
    fin_ovf = ovf_hit | big;
    fin_q   = fin_ovf ? sat : res;
  end

  always_ff @(posedge clk) begin
    if (sclr) begin
      a_q   <= '0;
      b_q   <= '0;
      q_q   <= '0;
      rem_q <= '0;
      dvd_q <= '0;
      quo_q <= '0;
      dvz_q <= 1'b0;
      ovf_q <= 1'b0;
`ifdef FXP_DIV_SIGNED_EN
      sign_q <= 1'b0;
`endif
    end else begin
      if (accept) begin
        a_q   <= a_in;
        b_q   <= b_in;
        q_q   <= '0;
        dvz_q <= 1'b0;
        ovf_q <= 1'b0;
`ifdef FXP_DIV_SIGNED_EN
        sign_q <= bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
`endif
      end
      if (load) begin
        rem_q <= '0;
        dvd_q <= N'(a_q) << FRAC;
        quo_q <= '0;
        if (b_q == '0) dvz_q <= 1'b1;
      end
      if (shift) begin
        rem_q <= qbit ? trial[WIDTH:0] : shifted[WIDTH:0];
        dvd_q <= dvd_q << 1;
        quo_q <= {quo_q[WIDTH-3:0], qbit};
        if (fin) begin
          q_q   <= fin_q;
          ovf_q <= fin_ovf;
        end
      end
    end
  end

  assign bus.q     = q_q;
  assign bus.valid = done;
  assign bus.busy  = busy;
  assign bus.dvz   = dvz_q;
  assign bus.ovf   = ovf_q;
endmodule

// File: tb/tb_fxp_div_param.sv
// tb_fxp_div_param -- directed and random checks of fxp_div_param against
// an arithmetic reference model.
module tb_fxp_div_param;
  localparam int W = 16;
  localparam int F = 8;
  localparam int N = W + F;

  logic clk = 1'b0;
  logic sclr;
  always #5 clk = ~clk;

  fxp_div_if #(.WIDTH(W)) bif ();
  fxp_div_param #(.WIDTH(W), .FRAC(F)) dut (.clk(clk), .sclr(sclr), .bus(bif));

  int nassert = 0;
  int nfail   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nassert++;
    assert (got === exp) else begin
      nfail++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: plain integer division of magnitudes; latency derived from
  // the position of the first quotient bit that does not fit.
  function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] q, output logic o,
                                output logic z, output int lat);
    longint ma, mb, quo;
    bit neg;
    int k;
    q = '0; o = 1'b0; z = 1'b0; lat = N + 2; neg = 1'b0; k = 0;
    ma = longint'(a);
    mb = longint'(b);
`ifdef FXP_DIV_SIGNED_EN
    if (a[W-1]) ma = (longint'(1) << W) - ma;
    if (b[W-1]) mb = (longint'(1) << W) - mb;
    neg = a[W-1] ^ b[W-1];
`endif
    if (mb == 0) begin
      z = 1'b1; lat = 2;
      return;
    end
    quo = (ma << F) / mb;
    if (quo >= (longint'(1) << W)) begin
      o = 1'b1;
      for (int i = 0; i < N; i++) if (quo[i]) k = i;
      lat = N + 2 - k;
    end
`ifdef FXP_DIV_SIGNED_EN
    else if (neg ? (quo > (longint'(1) << (W-1))) : (quo > (longint'(1) << (W-1)) - 1))
      o = 1'b1;
    if (o) q = neg ? W'(longint'(1) << (W-1)) : W'((longint'(1) << (W-1)) - 1);
    else   q = neg ? W'(-quo) : W'(quo);
`else
    q = o ? '1 : W'(quo);
`endif
  endfunction

  task automatic run(input logic [W-1:0] a, input logic [W-1:0] b, input bit inject);
    logic [W-1:0] eq;
    logic eo, ez;
    int elat, cyc;
    model(a, b, eq, eo, ez, elat);
    @(negedge clk);
    bif.a = a; bif.b = b; bif.start = 1'b1;
    cyc = 0;
    do begin
      @(posedge clk); #1;
      cyc++;
      if (cyc == 1) begin
        bif.start = 1'b0;
        chk("busy_in_load", bif.busy, 1);
      end
      if (inject && cyc == 5) begin
        bif.a = W'($urandom); bif.b = W'($urandom); bif.start = 1'b1;
      end
      if (inject && cyc == 6) bif.start = 1'b0;
    end while (!bif.valid && cyc < N + 10);
    chk("valid_seen", bif.valid, 1);
    chk("latency", cyc, elat);
    chk("q", bif.q, eq);
    chk("dvz", bif.dvz, ez);
    chk("ovf", bif.ovf, eo);
    chk("busy_in_done", bif.busy, 0);
    @(posedge clk); #1;
    chk("valid_one_cycle", bif.valid, 0);
    chk("q_hold", bif.q, eq);
  endtask

  initial begin
    int seen;
    logic [W-1:0] ra, rb;
    sclr = 1'b1; bif.start = 1'b0; bif.a = '0; bif.b = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_q", bif.q, 0);
    chk("rst_valid", bif.valid, 0);
    chk("rst_busy", bif.busy, 0);
    chk("rst_dvz", bif.dvz, 0);
    chk("rst_ovf", bif.ovf, 0);
    @(negedge clk); sclr = 1'b0;

    // Spec vectors
    run(16'h0300, 16'h0200, 1'b0);
    chk("v030_q", bif.q, 16'h0180);
    run(16'h1234, 16'h0000, 1'b0);
    chk("v031_dvz", bif.dvz, 1);
    chk("v031_q", bif.q, 16'h0000);
    run(16'h7F00, 16'h0001, 1'b0);
    chk("v032_ovf", bif.ovf, 1);
`ifndef FXP_DIV_SIGNED_EN
    chk("v032_q", bif.q, 16'hFFFF);
`else
    run(16'hFD00, 16'h0200, 1'b0);
    chk("v035a_q", bif.q, 16'hFE80);
    run(16'h7F00, 16'hFF00, 1'b0);
    chk("v035b_q", bif.q, 16'h8100);
    chk("v035b_ovf", bif.ovf, 0);
`endif

    // Reset mid-division: nothing completes afterwards
    @(negedge clk);
    bif.a = 16'h0300; bif.b = 16'h0200; bif.start = 1'b1;
    @(posedge clk); #1 bif.start = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk); sclr = 1'b1;
    @(posedge clk); #1;
    chk("midrst_busy", bif.busy, 0);
    chk("midrst_valid", bif.valid, 0);
    @(negedge clk); sclr = 1'b0;
    seen = 0;
    repeat (N + 5) begin
      @(posedge clk); #1;
      if (bif.valid) seen++;
    end
    chk("midrst_no_valid", seen, 0);
    run(16'h0100, 16'h0100, 1'b0);
    chk("v033_q", bif.q, 16'h0100);

    // start during ITER is ignored
    run(16'h0500, 16'h0300, 1'b1);
    run(16'hA5A5, 16'h1234, 1'b1);

    // Held start restarts after DONE -> IDLE
    @(negedge clk);
    bif.a = 16'h1234; bif.b = 16'h0000; bif.start = 1'b1;
    repeat (4) @(posedge clk);
    #1 chk("level_busy_again", bif.busy, 1);
    @(posedge clk); #1;
    chk("level_valid_again", bif.valid, 1);
    chk("level_dvz", bif.dvz, 1);
    bif.start = 1'b0;
    repeat (3) @(posedge clk);

    // Random operands, biased toward zero and small divisors
    for (int i = 0; i < 40; i++) begin
      ra = W'($urandom);
      case ($urandom_range(0, 7))
        0:       rb = '0;
        1, 2:    rb = W'($urandom_range(1, 255));
        default: rb = W'($urandom);
      endcase
      run(ra, rb, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nassert, nfail);
    $finish;
  end
endmodule
